cla8_serial_adder: RTL and testbench



---
 rtl/cla8_serial_adder_pkg.sv | 17 +
 rtl/cla8_serial_adder_if.sv | 31 +++
 rtl/cla8.sv | 30 +++
 rtl/cla8_serial_adder_carry_fix.sv | 16 +
 rtl/cla8_serial_adder.sv | 86 ++++++++
 tb/tb_cla8_serial_adder.sv | 163 ++++++++++++++++
 6 files changed

// File: rtl/cla8_serial_adder_pkg.sv
// Shared types for the byte-serial CLA8 adder: byte width, FSM states, index sizing.
package cla8_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-byte operand would still need a 1-bit index register.
  function automatic int idx_w(input int nbytes);
    return (nbytes < 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/cla8_serial_adder_if.sv
// Operand/result handshakes plus the byte lane to and from the external CLA8.
interface cla8_serial_adder_if
  import cla8_seq_pkg::*;
#(
  parameter int NBYTES = 4
);

  logic                     in_valid;
  logic                     in_ready;
  logic [BYTE_W*NBYTES-1:0] in_a;
  logic [BYTE_W*NBYTES-1:0] in_b;
  logic [BYTE_W-1:0]        add_a;
  logic [BYTE_W-1:0]        add_b;
  logic [BYTE_W-1:0]        add_sum;
  logic                     add_cout;
  logic                     out_valid;
  logic                     out_ready;
  logic [BYTE_W*NBYTES-1:0] out_sum;
  logic                     out_cout;

  modport slave (
    input  in_valid, in_a, in_b, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, out_valid, out_sum, out_cout
  );

  modport master (
    output in_valid, in_a, in_b, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_sum, out_cout
  );

endinterface

// File: rtl/cla8.sv
// Combinational 8-bit carry-lookahead adder without carry-in.
// Generate/propagate terms feed a fully flattened carry chain.
module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [7:0] c;
  logic       cc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c  = '0;
    cc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c[i] = cc;
      cc   = g[i] | (p[i] & cc);
    end
  end

  assign sum  = p ^ c;
  assign cout = cc;

endmodule

// File: rtl/cla8_serial_adder_carry_fix.sv
// Folds the previous byte's carry into a carry-in-less CLA8 result, one cycle, no state.
module cla8_carry_fix
  import cla8_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] add_sum,
  input  logic              carry,
  input  logic              add_cout,
  output logic [BYTE_W-1:0] fixed,
  output logic              carry_next
);

  assign fixed = add_sum + {{(BYTE_W-1){1'b0}}, carry};
  // Incrementing 0xFF is the only way the injected carry can ripple out.
  assign carry_next = add_cout | (carry & (&add_sum));

endmodule

// File: rtl/cla8_serial_adder.sv
// Byte-serial wide adder around an external CLA8: NBYTES+1 cycles accept-to-result.
// Single transaction in flight; result held in DONE until out_ready.
module cla8_serial_adder
  import cla8_seq_pkg::*;
#(
  parameter int NBYTES = 4
)(
  input  logic clk,
  input  logic rst,
  cla8_serial_adder_if.slave bus
);

  localparam int             IW   = idx_w(NBYTES);
  localparam logic [IW-1:0]  LAST = IW'(NBYTES - 1);

  state_t                               state;
  logic [NBYTES-1:0][BYTE_W-1:0]        op_a;
  logic [NBYTES-1:0][BYTE_W-1:0]        op_b;
  logic [NBYTES-1:0][BYTE_W-1:0]        res;
  logic [IW-1:0]                        idx;
  logic                                 carry;
  logic                                 out_valid_q;
  logic                                 out_cout_q;
  logic [BYTE_W-1:0]                    fixed;
  logic                                 carry_next;
  logic                                 busy;

  assign busy          = (state == BUSY) && !rst;
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.add_a     = busy ? op_a[idx] : '0;
  assign bus.add_b     = busy ? op_b[idx] : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = res;
  assign bus.out_cout  = out_cout_q;

  cla8_carry_fix u_carry_fix (
    .add_sum    (bus.add_sum),
    .carry      (carry),
    .add_cout   (bus.add_cout),
    .fixed      (fixed),
    .carry_next (carry_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      res         <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      out_valid_q <= 1'b0;
      out_cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a  <= bus.in_a;
            op_b  <= bus.in_b;
            idx   <= '0;
            carry <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          res[idx] <= fixed;
          carry    <= carry_next;
          idx      <= idx + 1'b1;
          if (idx == LAST) begin
            out_cout_q  <= carry_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla8_serial_adder.sv
// Bench for cla8_serial_adder with a real cla8 on the byte lane; golden model is plain wide addition.
module tb_cla8_serial_adder;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla8_serial_adder_if #(.NBYTES(NB)) bus ();

  cla8_serial_adder #(.NBYTES(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cla8 u_cla8 (
    .a    (bus.add_a),
    .b    (bus.add_b),
    .sum  (bus.add_sum),
    .cout (bus.add_cout)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a/b after some idle cycles and returns just past the accepting edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      bus.in_a = $urandom;
      bus.in_b = $urandom;
      @(negedge clk);
    end
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      $fatal(1, "FAIL in_ready never rose");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
  endtask

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int gap, input int hold);
    logic [W:0] gold;
    int lat;
    gold = {1'b0, a} + {1'b0, b};
    accept(a, b, gap);
    @(negedge clk);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      if (lat <= NB) begin
        check("add_a", bus.add_a, a[8*(lat-1) +: 8]);
        check("add_b", bus.add_b, b[8*(lat-1) +: 8]);
      end
      check("in_ready_busy", bus.in_ready, 0);
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      check("result_timeout", 0, 1);
      $fatal(1, "FAIL out_valid never rose");
    end
    check("latency", lat, NB + 1);
    check("out_sum", bus.out_sum, gold[W-1:0]);
    check("out_cout", bus.out_cout, gold[W]);
    check("add_a_done", bus.add_a, 0);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_sum", bus.out_sum, gold[W-1:0]);
      check("hold_cout", bus.out_cout, gold[W]);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("post_in_ready", bus.in_ready, 1);
    check("post_out_valid", bus.out_valid, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W-1:0] rst_a;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_sum", bus.out_sum, 0);
    check("reset_out_cout", bus.out_cout, 0);
    check("reset_add_a", bus.add_a, 0);
    check("reset_add_b", bus.add_b, 0);

    run_txn(32'h0000_00FF, 32'h0000_0001, 0, 0);
    run_txn(32'hFFFF_FFFF, 32'h0000_0001, 1, 0);
    run_txn(32'h1234_5678, 32'h1111_1111, 0, 0);
    run_txn(32'hDEAD_BEEF, 32'h2152_4111, 0, 3);

    // Abort while the third byte is on the adder lane.
    rst_a = 32'hA1B2_C3D4;
    accept(rst_a, 32'h0102_0304, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort_idx2_add_a", bus.add_a, rst_a[23:16]);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_in_ready", bus.in_ready, 0);
    check("abort_rst_out_valid", bus.out_valid, 0);
    rst = 1'b0;
    #1;
    check("abort_in_ready", bus.in_ready, 1);
    repeat (NB + 2) begin
      @(negedge clk);
      check("abort_out_valid", bus.out_valid, 0);
    end
    run_txn(32'h8000_0000, 32'h8000_0000, 0, 0);

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0:       begin ra = '1;       rb = $urandom_range(0, 255); end
        1:       begin ra = $urandom; rb = ~ra + 32'($urandom_range(0, 2)); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      run_txn(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
